// File: rtl/proc_seq.sv
// rtl/proc_seq.sv - multi-cycle control sequencer and register file for the 16-bit basic CPU
module proc_seq #(
    parameter int unsigned word = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [word-1:0] din,
    output logic            done,
    output logic [1:0]      alu_op,
    output logic [word-1:0] alu_a,
    output logic [word-1:0] alu_bus,
    input  logic [word-1:0] alu_g,
    output logic [word-1:0] bus_out
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [1:0] ALU_NOP = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;

    state_t          state_q, state_d;
    logic [8:0]      ir_q, ir_d;
    logic [word-1:0] a_q, a_d;
    logic [word-1:0] g_q, g_d;
    logic [word-1:0] regs_q [8];

    logic [2:0]      opcode;
    logic [2:0]      rx;
    logic [2:0]      ry;
    logic [word-1:0] bus;
    logic            reg_we;
    logic [2:0]      reg_waddr;

    assign opcode = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];

    // Sequencing and bus steering; every register write takes its data from the bus.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        a_d       = a_q;
        g_d       = g_q;
        bus       = '0;
        done      = 1'b0;
        alu_op    = ALU_NOP;
        reg_we    = 1'b0;
        reg_waddr = rx;

        case (state_q)
            T0: begin
                if (run) begin
                    ir_d    = din[8:0];
                    state_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus     = regs_q[ry];
                        reg_we  = 1'b1;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        bus     = din;
                        reg_we  = 1'b1;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus     = regs_q[rx];
                        a_d     = bus;
                        state_d = T2;
                    end
                    default: begin
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                bus     = regs_q[ry];
                alu_op  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                g_d     = alu_g;
                state_d = T3;
            end
            T3: begin
                bus     = g_q;
                reg_we  = 1'b1;
                done    = 1'b1;
                state_d = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            if (reg_we) begin
                regs_q[reg_waddr] <= bus;
            end
        end
    end

    assign alu_a   = a_q;
    assign alu_bus = bus;
    assign bus_out = bus;

endmodule

// File: tb/tb_proc_seq.sv
// tb/tb_proc_seq.sv - directed vector bench for proc_seq with a behavioural ALU
module tb_proc_seq;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] din;
    logic        done;
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_bus;
    logic [15:0] alu_g;
    logic [15:0] bus_out;

    int checks;
    int failures;

    proc_seq #(.word(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .din     (din),
        .done    (done),
        .alu_op  (alu_op),
        .alu_a   (alu_a),
        .alu_bus (alu_bus),
        .alu_g   (alu_g),
        .bus_out (bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            2'b01:   alu_g = alu_a + alu_bus;
            2'b10:   alu_g = alu_a - alu_bus;
            default: alu_g = 16'h0000;
        endcase
    end

    typedef struct {
        logic        run;
        logic [15:0] din;
        logic        done;
        logic [1:0]  op;
        logic [15:0] bus;
        logic [15:0] a;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic r, input logic [15:0] d, input logic dn,
                     input logic [1:0] op, input logic [15:0] b, input logic [15:0] a);
        vec_t e;
        e.run = r; e.din = d; e.done = dn; e.op = op; e.bus = b; e.a = a;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [15:0] d);
        run = r;
        din = d;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        run = 1'b1;
        din = 16'h0048;
        adv();
        adv();
        rst = 1'b0;
        drive(1'b0, 16'h0000);
        chk("reset_done", {15'd0, done}, 16'd0);
        chk("reset_op", {14'd0, alu_op}, 16'd0);
        chk("reset_a", alu_a, 16'h0000);
        chk("reset_bus", bus_out, 16'h0000);

        // run, din, done, alu_op, bus, A
        v(0, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000);
        v(1, 16'h0040, 0, 2'd0, 16'h0000, 16'h0000);
        v(0, 16'h1234, 1, 2'd0, 16'h1234, 16'h0000);
        v(1, 16'h0008, 0, 2'd0, 16'h0000, 16'h0000);
        v(0, 16'h0000, 1, 2'd0, 16'h1234, 16'h0000);
        v(1, 16'h0009, 0, 2'd0, 16'h0000, 16'h0000);
        v(1, 16'h0000, 1, 2'd0, 16'h1234, 16'h0000);
        v(1, 16'h0040, 0, 2'd0, 16'h0000, 16'h0000);
        v(0, 16'h0005, 1, 2'd0, 16'h0005, 16'h0000);
        v(1, 16'h0048, 0, 2'd0, 16'h0000, 16'h0000);
        v(0, 16'h0007, 1, 2'd0, 16'h0007, 16'h0000);
        v(1, 16'h0081, 0, 2'd0, 16'h0000, 16'h0000);
        v(1, 16'h0000, 0, 2'd0, 16'h0005, 16'h0000);
        v(0, 16'h0000, 0, 2'd1, 16'h0007, 16'h0005);
        v(1, 16'h0000, 1, 2'd0, 16'h000C, 16'h0005);
        v(0, 16'h0000, 0, 2'd0, 16'h0000, 16'h0005);
        v(1, 16'h0000, 0, 2'd0, 16'h0000, 16'h0005);
        v(0, 16'h0000, 1, 2'd0, 16'h000C, 16'h0005);
        v(1, 16'h0050, 0, 2'd0, 16'h0000, 16'h0005);
        v(0, 16'h0000, 1, 2'd0, 16'h0000, 16'h0005);
        v(1, 16'h0058, 0, 2'd0, 16'h0000, 16'h0005);
        v(0, 16'h0001, 1, 2'd0, 16'h0001, 16'h0005);
        v(1, 16'h00D3, 0, 2'd0, 16'h0000, 16'h0005);
        v(0, 16'h0000, 0, 2'd0, 16'h0000, 16'h0005);
        v(0, 16'h0000, 0, 2'd2, 16'h0001, 16'h0000);
        v(0, 16'h0000, 1, 2'd0, 16'hFFFF, 16'h0000);
        v(1, 16'h0093, 0, 2'd0, 16'h0000, 16'h0000);
        v(0, 16'h0000, 0, 2'd0, 16'hFFFF, 16'h0000);
        v(0, 16'h0000, 0, 2'd1, 16'h0001, 16'hFFFF);
        v(0, 16'h0000, 1, 2'd0, 16'h0000, 16'hFFFF);
        v(1, 16'h01C0, 0, 2'd0, 16'h0000, 16'hFFFF);
        v(0, 16'h5555, 1, 2'd0, 16'h0000, 16'hFFFF);
        v(1, 16'hFE12, 0, 2'd0, 16'h0000, 16'hFFFF);
        v(1, 16'h0000, 1, 2'd0, 16'h0000, 16'hFFFF);
        v(1, 16'h0000, 0, 2'd0, 16'h0000, 16'hFFFF);
        v(1, 16'h0000, 1, 2'd0, 16'h000C, 16'hFFFF);
        v(1, 16'h0089, 0, 2'd0, 16'h0000, 16'hFFFF);
        v(0, 16'h0000, 0, 2'd0, 16'h0007, 16'hFFFF);
        v(0, 16'h0000, 0, 2'd1, 16'h0007, 16'h0007);
        v(0, 16'h0000, 1, 2'd0, 16'h000E, 16'h0007);
        v(0, 16'h0000, 0, 2'd0, 16'h0000, 16'h0007);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].run, tbl[i].din);
            chk($sformatf("v%0d_done", i), {15'd0, done}, {15'd0, tbl[i].done});
            chk($sformatf("v%0d_op", i), {14'd0, alu_op}, {14'd0, tbl[i].op});
            chk($sformatf("v%0d_bus", i), bus_out, tbl[i].bus);
            chk($sformatf("v%0d_alu_bus", i), alu_bus, tbl[i].bus);
            chk($sformatf("v%0d_a", i), alu_a, tbl[i].a);
            adv();
        end

        // add R0,R1 abandoned by reset while in T2
        drive(1'b1, 16'h0081);
        adv();
        drive(1'b0, 16'h0000);
        chk("mid_t1_bus", bus_out, 16'h000C);
        adv();
        drive(1'b0, 16'h0000);
        chk("mid_t2_op", {14'd0, alu_op}, 16'd1);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        drive(1'b0, 16'h0000);
        chk("rst_mid_done", {15'd0, done}, 16'd0);
        chk("rst_mid_op", {14'd0, alu_op}, 16'd0);
        chk("rst_mid_a", alu_a, 16'h0000);
        chk("rst_mid_bus", bus_out, 16'h0000);
        adv();
        drive(1'b0, 16'h0000);
        chk("rst_idle_done", {15'd0, done}, 16'd0);
        adv();

        for (int r = 0; r < 8; r++) begin
            logic [15:0] ins;
            ins = 16'(r * 9);
            drive(1'b1, ins);
            adv();
            drive(1'b0, 16'h0000);
            chk($sformatf("clr_r%0d", r), bus_out, 16'h0000);
            chk($sformatf("clr_r%0d_done", r), {15'd0, done}, 16'd1);
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
